// File: rtl/miniarm_mem_pkg.sv
// Shared memory-subsystem definitions for the miniARMv7 data RAM and the cache that will follow it.
package miniarm_mem_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Widest word merge_bytes can handle; callers zero-extend narrower words and truncate the result.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  typedef enum logic {
    CLEAR,
    RUN
  } ram_state_t;

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BYTES-1:0]  mask
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Read return pipeline: carries {valid, err, data} through RD_LAT stages; each stage holds its data
// between valid entries so the last returned word stays visible on the output.
module ram_read_pipe
  import miniarm_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0]             valid_q, valid_d;
  logic [RD_LAT-1:0]             err_q, err_d;
  logic [RD_LAT-1:0][DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d    = '0;
    err_d      = '0;
    data_d     = data_q;
    valid_d[0] = in_valid;
    err_d[0]   = in_valid && in_err;
    if (in_valid) begin
      data_d[0] = in_data;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/banked_mask_ram.sv
// Word-addressed data RAM with byte-masked writes, configurable read latency and read-during-write
// policy, a zero-fill sweep after reset, and range checking on both ports.
module banked_mask_ram
  import miniarm_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_WRITE_FIRST
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_wEN,
  input  logic [DATA_W/8-1:0] io_wMask,
  input  logic [ADDR_W-1:0]   io_addrW,
  input  logic [DATA_W-1:0]   io_dataW,
  input  logic                io_rEN,
  input  logic [ADDR_W-1:0]   io_addrR,
  output logic [DATA_W-1:0]   io_dataR,
  output logic                io_rValid,
  output logic                io_rErr,
  output logic                io_wErr,
  output logic                io_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  if (DATA_W < 8 || DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("banked_mask_ram: DATA_W must be a multiple of 8 between 8 and %0d", MAX_DATA_W);
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("banked_mask_ram: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("banked_mask_ram: DEPTH must be at least 2");
  end
  if (ADDR_W < IDX_W || ADDR_W > 64) begin : g_bad_addr_w
    $error("banked_mask_ram: ADDR_W must cover DEPTH and be at most 64");
  end
  if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : g_bad_rdw
    $error("banked_mask_ram: RDW_MODE must be 0 or 1");
  end

  ram_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             werr_q, werr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              w_in_range, r_in_range;
  logic              w_req, r_req;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic [DATA_W-1:0] old_word, rd_word, merged_word;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              pipe_in_valid, pipe_in_err;
  logic [DATA_W-1:0] pipe_in_data;
  logic              pipe_valid, pipe_err;
  logic [DATA_W-1:0] pipe_data;

  // Compare the full address so upper bits can never alias onto a valid entry.
  assign w_in_range = 64'(io_addrW) < 64'(DEPTH);
  assign r_in_range = 64'(io_addrR) < 64'(DEPTH);
  assign w_idx      = io_addrW[IDX_W-1:0];
  assign r_idx      = io_addrR[IDX_W-1:0];

  assign w_req = (state_q == RUN) && io_wEN && !reset;
  assign r_req = (state_q == RUN) && io_rEN;

  assign old_word    = mem_q[w_idx];
  assign rd_word     = mem_q[r_idx];
  assign merged_word = DATA_W'(merge_bytes(MAX_DATA_W'(old_word), MAX_DATA_W'(io_dataW),
                                           MAX_BYTES'(io_wMask)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    werr_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = w_idx;
    mem_wdata = merged_word;
    case (state_q)
      CLEAR: begin
        mem_we    = !reset;
        mem_waddr = idx_q;
        mem_wdata = '0;
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RUN: begin
        mem_we = w_req && w_in_range && (|io_wMask);
        werr_d = w_req && !w_in_range;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      werr_q  <= werr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Same-address bypass: write-first forwards the merged word, read-first keeps the array value.
  always_comb begin
    pipe_in_valid = r_req;
    pipe_in_err   = !r_in_range;
    pipe_in_data  = '0;
    if (r_in_range) begin
      pipe_in_data = rd_word;
      if (RDW_MODE == RDW_WRITE_FIRST && w_req && w_in_range && io_addrW == io_addrR) begin
        pipe_in_data = merged_word;
      end
    end
  end

  ram_read_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_read_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (pipe_in_valid),
    .in_err    (pipe_in_err),
    .in_data   (pipe_in_data),
    .out_valid (pipe_valid),
    .out_err   (pipe_err),
    .out_data  (pipe_data)
  );

  assign io_busy   = reset || (state_q == CLEAR);
  assign io_dataR  = reset ? '0 : pipe_data;
  assign io_rValid = !reset && pipe_valid;
  assign io_rErr   = !reset && pipe_valid && pipe_err;
  assign io_wErr   = !reset && werr_q;

endmodule

// File: tb/tb_banked_mask_ram.sv
// Directed bench for banked_mask_ram: two instances share stimulus, one write-first with RD_LAT=1,
// one read-first with RD_LAT=2, each compared against hand-computed values.
module tb_banked_mask_ram;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wEN   = 1'b0;
  logic [3:0]  wMask = 4'h0;
  logic [31:0] addrW = 32'h0;
  logic [31:0] dataW = 32'h0;
  logic        rEN   = 1'b0;
  logic [31:0] addrR = 32'h0;

  logic [31:0] dataRA, dataRB;
  logic        rValidA, rValidB, rErrA, rErrB, wErrA, wErrB, busyA, busyB;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  banked_mask_ram #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1), .RDW_MODE(0)
  ) dutA (
    .clock(clock), .reset(reset), .io_wEN(wEN), .io_wMask(wMask), .io_addrW(addrW),
    .io_dataW(dataW), .io_rEN(rEN), .io_addrR(addrR), .io_dataR(dataRA),
    .io_rValid(rValidA), .io_rErr(rErrA), .io_wErr(wErrA), .io_busy(busyA)
  );

  banked_mask_ram #(
    .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2), .RDW_MODE(1)
  ) dutB (
    .clock(clock), .reset(reset), .io_wEN(wEN), .io_wMask(wMask), .io_addrW(addrW),
    .io_dataW(dataW), .io_rEN(rEN), .io_addrR(addrR), .io_dataR(dataRB),
    .io_rValid(rValidB), .io_rErr(rErrB), .io_wErr(wErrB), .io_busy(busyB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] mask, input logic [31:0] aw,
                               input logic [31:0] dw, input logic re, input logic [31:0] ar);
    wEN   = we;
    wMask = mask;
    addrW = aw;
    dataW = dw;
    rEN   = re;
    addrR = ar;
    @(posedge clock);
    #1;
    wEN = 1'b0;
    rEN = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic resetAndSweep(input string tag);
    int  busyCount;
    logic sawValid, sawWErr;
    reset = 1'b1;
    wEN   = 1'b0;
    rEN   = 1'b0;
    #1;
    checkOutput({tag, "_rst_valid"}, 64'(rValidA | rValidB), 64'd0);
    checkOutput({tag, "_rst_busy"}, 64'(busyA & busyB), 64'd1);
    @(posedge clock);
    #1;
    checkOutput({tag, "_rst_dataA"}, 64'(dataRA), 64'd0);
    checkOutput({tag, "_rst_dataB"}, 64'(dataRB), 64'd0);
    checkOutput({tag, "_rst_flags"}, 64'({rValidA, rErrA, wErrA, rValidB, rErrB, wErrB}), 64'd0);
    reset = 1'b0;
    busyCount = 0;
    sawValid  = 1'b0;
    sawWErr   = 1'b0;
    wEN   = 1'b1;
    wMask = 4'hF;
    addrW = 32'd20;
    dataW = 32'hDEAD_BEEF;
    rEN   = 1'b1;
    addrR = 32'd5;
    while (busyA && busyCount < 100) begin
      busyCount++;
      @(posedge clock);
      #1;
      sawValid = sawValid | rValidA | rValidB;
      sawWErr  = sawWErr | wErrA | wErrB;
    end
    wEN = 1'b0;
    rEN = 1'b0;
    checkOutput({tag, "_busy_cycles"}, 64'(busyCount), 64'(DEPTH));
    checkOutput({tag, "_busyB_done"}, 64'(busyB), 64'd0);
    checkOutput({tag, "_no_valid_busy"}, 64'(sawValid), 64'd0);
    checkOutput({tag, "_no_werr_busy"}, 64'(sawWErr), 64'd0);
  endtask

  task automatic rwCheck(input string tag, input logic we, input logic [3:0] mask,
                         input logic [31:0] aw, input logic [31:0] dw, input logic [31:0] ar,
                         input logic [31:0] expA, input logic [31:0] expB, input logic expErr,
                         input logic expWErr);
    applyStimulus(we, mask, aw, dw, 1'b1, ar);
    checkOutput({tag, "_A_valid"}, 64'(rValidA), 64'd1);
    checkOutput({tag, "_A_data"}, 64'(dataRA), 64'(expA));
    checkOutput({tag, "_A_err"}, 64'(rErrA), 64'(expErr));
    checkOutput({tag, "_B_early"}, 64'(rValidB), 64'd0);
    checkOutput({tag, "_wErr"}, 64'({wErrA, wErrB}), expWErr ? 64'd3 : 64'd0);
    idleCycle();
    checkOutput({tag, "_A_done"}, 64'(rValidA), 64'd0);
    checkOutput({tag, "_B_valid"}, 64'(rValidB), 64'd1);
    checkOutput({tag, "_B_data"}, 64'(dataRB), 64'(expB));
    checkOutput({tag, "_B_err"}, 64'(rErrB), 64'(expErr));
    checkOutput({tag, "_wErr_gone"}, 64'({wErrA, wErrB}), 64'd0);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] ar, input logic [31:0] expA,
                           input logic [31:0] expB, input logic expErr);
    rwCheck(tag, 1'b0, 4'h0, 32'h0, 32'h0, ar, expA, expB, expErr, 1'b0);
  endtask

  initial begin
    resetAndSweep("init");
    readCheck("sweep5", 32'd5, 32'h0, 32'h0, 1'b0);

    applyStimulus(1'b1, 4'hF, 32'd0, 32'h0000_007B, 1'b0, 32'h0);
    readCheck("rd0", 32'd0, 32'h7B, 32'h7B, 1'b0);

    applyStimulus(1'b1, 4'hF, 32'd1, 32'h1122_3344, 1'b0, 32'h0);
    applyStimulus(1'b1, 4'b0101, 32'd1, 32'hAABB_CCDD, 1'b0, 32'h0);
    readCheck("merge1", 32'd1, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0);

    rwCheck("rdw2", 1'b1, 4'hF, 32'd2, 32'h315, 32'd2, 32'h315, 32'h0, 1'b0, 1'b0);
    readCheck("rd2", 32'd2, 32'h315, 32'h315, 1'b0);
    rwCheck("rdw1p", 1'b1, 4'b0001, 32'd1, 32'h0000_00EE, 32'd1,
            32'h11BB_33EE, 32'h11BB_33DD, 1'b0, 1'b0);

    rwCheck("oor", 1'b1, 4'hF, 32'(DEPTH), 32'h0000_0BAD, 32'hFFFF_FFFF,
            32'h0, 32'h0, 1'b1, 1'b1);
    readCheck("alias0", 32'd0, 32'h7B, 32'h7B, 1'b0);

    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'd0);
    checkOutput("b2b_1_A", 64'({rValidA, dataRA}), {31'd0, 1'b1, 32'h7B});
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'd1);
    checkOutput("b2b_2_A", 64'({rValidA, dataRA}), {31'd0, 1'b1, 32'h11BB_33EE});
    checkOutput("b2b_2_B", 64'({rValidB, dataRB}), {31'd0, 1'b1, 32'h7B});
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'd2);
    checkOutput("b2b_3_A", 64'({rValidA, dataRA}), {31'd0, 1'b1, 32'h315});
    checkOutput("b2b_3_B", 64'({rValidB, dataRB}), {31'd0, 1'b1, 32'h11BB_33EE});
    idleCycle();
    checkOutput("b2b_4_A_hold", 64'({rValidA, dataRA}), {31'd0, 1'b0, 32'h315});
    checkOutput("b2b_4_B", 64'({rValidB, dataRB}), {31'd0, 1'b1, 32'h315});
    idleCycle();
    checkOutput("b2b_5_B_done", 64'(rValidB), 64'd0);

    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'd0);
    checkOutput("mid_A_valid", 64'({rValidA, dataRA}), {31'd0, 1'b1, 32'h7B});
    resetAndSweep("mid");
    readCheck("post0", 32'd0, 32'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
